// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and constants for the ccff chain loader.
// Holds FSM state encoding and command codes.
package ccff_chain_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RDBK,
    ST_DONE
  } state_e;

  localparam logic CMD_LOAD = 1'b0;
  localparam logic CMD_RDBK = 1'b1;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/ccff_word_shifter.sv
// Word buffer: parallel-load/serial-out and serial-in/parallel-out
// with a count of valid bits.
module ccff_word_shifter
  import ccff_chain_loader_pkg::*;
#(
  parameter  int W    = 8,
  localparam int CNTW = $clog2(W + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic [W-1:0]    load_data_i,
  input  logic [CNTW-1:0] load_cnt_i,
  input  logic            shr_i,
  input  logic            shin_i,
  input  logic            sin_i,
  output logic [W-1:0]    data_o,
  output logic [CNTW-1:0] cnt_o,
  output logic            sout_o
);

  logic [W-1:0]    data_q, data_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (load_i) begin
      // bits past the valid count are zeroed
      for (int i = 0; i < W; i++) begin
        data_d[i] = (CNTW'(i) < load_cnt_i) & load_data_i[i];
      end
      cnt_d = load_cnt_i;
    end else if (shr_i) begin
      data_d = data_q >> 1;
      cnt_d  = cnt_q - CNTW'(1);
    end else if (shin_i) begin
      for (int i = 0; i < W; i++) begin
        if (CNTW'(i) == cnt_q) data_d[i] = sin_i;
      end
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o = data_q;
  assign cnt_o  = cnt_q;
  assign sout_o = data_q[0];

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads and reads back a configuration flop chain word by word,
// recirculating the chain on readback so its content survives.
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 32,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              cmd_valid,
  input  logic              cmd_rdbk,
  output logic              cmd_ready,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_clk_en,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int BW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN);

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            sh_clr, sh_load, sh_shr, sh_shin;
  logic [BW-1:0]   sh_load_cnt, buf_cnt;
  logic [WORD_W-1:0] buf_data;
  logic            buf_sout;
  int              used, room;

  ccff_word_shifter #(.W(WORD_W)) u_shifter (
    .clk        (prog_clk),
    .rst_n      (prog_reset_n),
    .clr_i      (sh_clr),
    .load_i     (sh_load),
    .load_data_i(cfg_data),
    .load_cnt_i (sh_load_cnt),
    .shr_i      (sh_shr),
    .shin_i     (sh_shin),
    .sin_i      (ccff_tail),
    .data_o     (buf_data),
    .cnt_o      (buf_cnt),
    .sout_o     (buf_sout)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    sh_clr      = 1'b0;
    sh_load     = 1'b0;
    sh_shr      = 1'b0;
    sh_shin     = 1'b0;
    sh_load_cnt = '0;
    cmd_ready   = 1'b0;
    cfg_ready   = 1'b0;
    rd_valid    = 1'b0;
    ccff_clk_en = 1'b0;
    ccff_head   = 1'b0;
    busy        = (state_q != ST_IDLE);
    done        = 1'b0;
    // bits already committed: shifted plus still buffered
    used        = int'(count_q) + int'(buf_cnt);
    room        = CHAIN_LEN - used;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = prog_reset_n;
        if (cmd_valid && cmd_ready) begin
          sh_clr  = 1'b1;
          count_d = '0;
          state_d = (cmd_rdbk == CMD_RDBK) ? ST_RDBK : ST_LOAD;
        end
      end
      ST_LOAD: begin
        // ready while the last buffered bit shifts, so no bubble
        cfg_ready = (buf_cnt <= BW'(1)) && (room > 0);
        if (buf_cnt != '0) begin
          ccff_clk_en = 1'b1;
          ccff_head   = buf_sout;
          sh_shr      = 1'b1;
          count_d     = count_q + CW'(1);
          if (count_q == LAST - CW'(1)) state_d = ST_DONE;
        end
        if (cfg_valid && cfg_ready) begin
          sh_load     = 1'b1;
          sh_load_cnt = BW'(min_int(WORD_W, room));
        end
      end
      ST_RDBK: begin
        ccff_head = ccff_tail;
        rd_valid  = (buf_cnt == BW'(WORD_W)) ||
                    ((count_q == LAST) && (buf_cnt != '0));
        if (!rd_valid && (count_q != LAST)) begin
          ccff_clk_en = 1'b1;
          sh_shin     = 1'b1;
          count_d     = count_q + CW'(1);
        end
        if (rd_valid && rd_ready) begin
          sh_clr = 1'b1;
          if (count_q == LAST) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign rd_data = buf_data;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench: two loaders (32- and 13-flop chains) driven against
// behavioural chain models and a bit-stream reference image.
module tb_ccff_chain_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] cmd_valid = '0;
  logic [1:0] cfg_valid = '0;
  logic [1:0] rd_ready = '0;
  logic       cmd_rdbk = 1'b0;
  logic [7:0] cfg_data = '0;
  logic [1:0] cmd_ready, cfg_ready, rd_valid;
  logic [1:0] clk_en, head, busy, done;
  logic [7:0] rdd0, rdd1;
  logic [31:0] ch0 = '0;
  logic [12:0] ch1 = '0;

  int vectors = 0;
  int misses = 0;
  logic [7:0]  lw [4];
  logic [31:0] ref_img [2];
  bit          ab;

  always #5 clk = ~clk;

  // chain models: head enters at index 0, tail is the top index
  always @(posedge clk) begin
    if (clk_en[0]) ch0 <= {ch0[30:0], head[0]};
    if (clk_en[1]) ch1 <= {ch1[11:0], head[1]};
  end

  ccff_chain_loader #(.CHAIN_LEN(32), .WORD_W(8)) u_dut0 (
    .prog_clk(clk), .prog_reset_n(rst_n),
    .cmd_valid(cmd_valid[0]), .cmd_rdbk(cmd_rdbk),
    .cmd_ready(cmd_ready[0]),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid[0]),
    .cfg_ready(cfg_ready[0]),
    .rd_data(rdd0), .rd_valid(rd_valid[0]),
    .rd_ready(rd_ready[0]),
    .ccff_head(head[0]), .ccff_tail(ch0[31]),
    .ccff_clk_en(clk_en[0]), .busy(busy[0]), .done(done[0])
  );

  ccff_chain_loader #(.CHAIN_LEN(13), .WORD_W(8)) u_dut1 (
    .prog_clk(clk), .prog_reset_n(rst_n),
    .cmd_valid(cmd_valid[1]), .cmd_rdbk(cmd_rdbk),
    .cmd_ready(cmd_ready[1]),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid[1]),
    .cfg_ready(cfg_ready[1]),
    .rd_data(rdd1), .rd_valid(rd_valid[1]),
    .rd_ready(rd_ready[1]),
    .ccff_head(head[1]), .ccff_tail(ch1[12]),
    .ccff_clk_en(clk_en[1]), .busy(busy[1]), .done(done[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      misses++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic int clen(input int sel);
    return (sel != 0) ? 13 : 32;
  endfunction

  // image bit i = i-th flop counted from the tail end
  function automatic logic [31:0] img(input int sel);
    logic [31:0] r = '0;
    if (sel == 0) for (int i = 0; i < 32; i++) r[i] = ch0[31-i];
    else for (int i = 0; i < 13; i++) r[i] = ch1[12-i];
    return r;
  endfunction

  function automatic logic [7:0] rdd(input int sel);
    return (sel != 0) ? rdd1 : rdd0;
  endfunction

  // loaded bit stream, first bit at the tail end
  function automatic logic [31:0] stream_img(input int n, input int nw);
    logic [31:0] r = '0;
    for (int k = 0; k < nw; k++)
      for (int b = 0; b < 8; b++)
        if (k * 8 + b < n) r[k*8+b] = lw[k][b];
    return r;
  endfunction

  task automatic rand_words();
    for (int k = 0; k < 4; k++) lw[k] = 8'($urandom);
  endtask

  task automatic do_load(input int sel, input int nw, input int gap_after,
                         input int gap_len, input int abort_at,
                         output bit aborted);
    int n = clen(sel);
    int wi = 0, en_n = 0, holes = 0, pend = 0, done_n = 0;
    int extra = 0, gap = gap_len, cyc = 0;
    bit started = 0;
    aborted = 0;
    @(negedge clk);
    cmd_rdbk = 1'b0;
    cmd_valid[sel] = 1'b1;
    chk("ld_cmd_ready", cmd_ready[sel], 1);
    @(negedge clk);
    cmd_valid[sel] = 1'b0;
    chk("ld_busy", busy[sel], 1);
    while (cyc < 300) begin
      if (wi == gap_after && gap > 0 && cfg_ready[sel]) begin
        cfg_valid[sel] = 1'b0;
        gap--;
      end else begin
        cfg_valid[sel] = 1'b1;
        cfg_data = (wi < nw) ? lw[wi] : 8'($urandom);
      end
      if (cfg_valid[sel] && cfg_ready[sel]) begin
        if (wi < nw) wi++;
        else extra++;
      end
      if (clk_en[sel]) begin
        en_n++; holes += pend; pend = 0; started = 1;
      end else if (started) pend++;
      if (done[sel]) done_n++;
      if (abort_at > 0 && en_n == abort_at) begin
        aborted = 1;
        return;
      end
      if (done_n > 0 && !done[sel]) break;
      @(negedge clk);
      cyc++;
    end
    cfg_valid[sel] = 1'b0;
    ref_img[sel] = stream_img(n, nw);
    chk("ld_words_taken", wi, nw);
    chk("ld_extra_words", extra, 0);
    chk("ld_shift_count", en_n, n);
    chk("ld_bubbles", holes, (gap_after >= 0) ? gap_len : 0);
    chk("ld_done_pulses", done_n, 1);
    chk("ld_image", img(sel), ref_img[sel]);
    chk("ld_idle_after", busy[sel], 0);
  endtask

  task automatic do_rdbk(input int sel, input int stall_idx,
                         input int stall_len);
    int n = clen(sel);
    int nexp = (n + 7) / 8;
    int en_n = 0, done_n = 0, wk = 0, st = 0, cyc = 0;
    int unstable = 0, shiftv = 0;
    logic [7:0] held = '0;
    logic [7:0] got [$];
    logic [31:0] rimg = ref_img[sel];
    @(negedge clk);
    cmd_rdbk = 1'b1;
    cmd_valid[sel] = 1'b1;
    chk("rb_cmd_ready", cmd_ready[sel], 1);
    @(negedge clk);
    cmd_valid[sel] = 1'b0;
    cmd_rdbk = 1'b0;
    while (cyc < 400) begin
      rd_ready[sel] = 1'b1;
      if (rd_valid[sel]) begin
        if (clk_en[sel]) shiftv++;
        if (wk == stall_idx && st < stall_len) begin
          rd_ready[sel] = 1'b0;
          if (st == 0) held = rdd(sel);
          else if (rdd(sel) !== held) unstable++;
          st++;
        end else begin
          got.push_back(rdd(sel));
          wk++;
        end
      end
      if (clk_en[sel]) en_n++;
      if (done[sel]) done_n++;
      if (done_n > 0 && !done[sel]) break;
      @(negedge clk);
      cyc++;
    end
    rd_ready[sel] = 1'b0;
    chk("rb_word_count", got.size(), nexp);
    for (int k = 0; k < nexp; k++) begin
      if (k < got.size()) chk($sformatf("rb_word%0d", k), got[k], rimg[k*8 +: 8]);
    end
    chk("rb_shift_count", en_n, n);
    chk("rb_shift_while_valid", shiftv, 0);
    chk("rb_done_pulses", done_n, 1);
    if (stall_len > 0) begin
      chk("rb_stall_cycles", st, stall_len);
      chk("rb_stall_stable", unstable, 0);
    end
    chk("rb_image_kept", img(sel), rimg);
  endtask

  initial begin
    #12;
    chk("rst_outs0", {clk_en[0], head[0], cfg_ready[0], rd_valid[0],
                      busy[0], done[0], cmd_ready[0]}, 0);
    chk("rst_outs1", {clk_en[1], head[1], cfg_ready[1], rd_valid[1],
                      busy[1], done[1], cmd_ready[1]}, 0);
    chk("rst_rdata", {rdd1, rdd0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", cmd_ready, 2'b11);
    chk("rel_busy", busy, 2'b00);

    lw[0] = 8'h01; lw[1] = 8'h80; lw[2] = 8'hFF; lw[3] = 8'h5A;
    do_load(0, 4, -1, 0, 0, ab);
    chk("img_5AFF8001", img(0), 32'h5AFF8001);
    do_rdbk(0, -1, 0);

    rand_words();
    do_load(0, 4, 2, 5, 0, ab);
    do_rdbk(0, 0, 10);

    lw[0] = 8'hAB; lw[1] = 8'h1F;
    do_load(1, 2, -1, 0, 0, ab);
    do_rdbk(1, -1, 0);

    rand_words();
    do_load(1, 2, 1, 3, 0, ab);
    do_rdbk(1, 1, 4 + int'($urandom_range(0, 5)));

    rand_words();
    do_load(0, 4, -1, 0, 17, ab);
    chk("abort_reached", ab, 1);
    cfg_valid = '0;
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_outs", {clk_en[0], head[0], cfg_ready[0], rd_valid[0],
                        busy[0], done[0], cmd_ready[0]}, 0);
    chk("midrst_rdata", rdd0, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_cmd_ready", cmd_ready[0], 1);

    rand_words();
    do_load(0, 4, -1, 0, 0, ab);
    do_rdbk(0, 3, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 32, meaning configuration flops in the attached ccff chain (legal range 1..4096).
REQ-002 SHALL have parameter WORD_W, default 8, meaning bits per load/readback data word (legal range 1..32).
REQ-003 SHALL have port prog_clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 SHALL have port prog_reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit, command request.
REQ-006 SHALL have port cmd_rdbk, input, 1 bit, command type: 0 = load, 1 = readback.
REQ-007 SHALL have port cmd_ready, output, 1 bit, high only in IDLE.
REQ-008 SHALL have ports cfg_data (input, WORD_W bits), cfg_valid (input, 1 bit) and cfg_ready (output, 1 bit), the load word stream.
REQ-009 SHALL have ports rd_data (output, WORD_W bits), rd_valid (output, 1 bit) and rd_ready (input, 1 bit), the readback word stream.
REQ-010 SHALL have port ccff_head, output, 1 bit, which drives the chain input.
REQ-011 SHALL have port ccff_tail, input, 1 bit, the chain output.
REQ-012 SHALL have port ccff_clk_en, output, 1 bit; the chain shifts only on prog_clk edges where it is 1.
REQ-013 SHALL have ports busy (output, 1 bit) and done (output, 1-cycle pulse).

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, RDBK, DONE.
REQ-015 IDLE: cmd_valid && cmd_ready moves to LOAD (cmd_rdbk=0) or RDBK (cmd_rdbk=1), clears bit counter to 0 and clears the word buffer.
REQ-016 LOAD: cfg_ready=1 when the word buffer is empty; a cfg_valid && cfg_ready handshake fills the buffer with min(WORD_W, CHAIN_LEN-count) valid bits.
REQ-017 LOAD shift cycle: when the buffer is non-empty, ccff_clk_en=1 and ccff_head = buffer bit 0 (LSB first); the buffer shifts right, count increments. A full word drains in WORD_W consecutive cycles.
REQ-018 LOAD: a handshake in the cycle the last buffered bit shifts makes the next cycle a shift cycle (no bubble); an empty buffer with cfg_valid=0 gives ccff_clk_en=0 (stall, chain holds).
REQ-019 LOAD bit order: the first bit shifted lands in the chain flop nearest ccff_tail after CHAIN_LEN shifts.
REQ-020 RDBK: ccff_head = ccff_tail (recirculate), so the chain content is restored after exactly CHAIN_LEN shifts; each shifted ccff_tail bit packs LSB-first into the capture word.
REQ-021 RDBK: rd_valid rises when the capture word holds WORD_W bits or count reaches CHAIN_LEN; unused upper bits are 0; the word is held stable until rd_ready.
REQ-022 RDBK: while rd_valid && !rd_ready, ccff_clk_en=0; on handshake, shifting resumes the next cycle.
REQ-023 After the CHAIN_LEN-th shift (and, in RDBK, the final word handshake) the FSM enters DONE; done=1 for one cycle; then IDLE.
REQ-024 Words beyond ceil(CHAIN_LEN/WORD_W) SHALL never be accepted (cfg_ready=0 outside LOAD and once count=CHAIN_LEN); cmd_valid outside IDLE is ignored.
REQ-025 count SHALL be $clog2(CHAIN_LEN+1) bits and never exceed CHAIN_LEN; ccff_clk_en SHALL be asserted exactly CHAIN_LEN times per command.
REQ-026 busy=1 in LOAD, RDBK and DONE; ccff_clk_en SHALL be registered-state-driven combinationally only from FSM/buffer state, not from ready inputs of the same cycle, except per REQ-022.

Reset
REQ-027 Asserting prog_reset_n low at any time SHALL force IDLE, with count=0, buffers=0, and ccff_clk_en, ccff_head, cfg_ready, rd_valid, busy and done all 0; cmd_ready=1 after release.
REQ-028 Reset mid-LOAD/RDBK SHALL leave chain content undefined; no partial command resumes.

Structure
REQ-029 A shared package SHALL hold the FSM state enum and the command encoding constants (CMD_LOAD=0, CMD_RDBK=1).
REQ-030 SHALL contain one sub-module, ccff_word_shifter (parallel-load/serial-out plus serial-in/parallel-out buffer with valid-bit count), used for both directions.

Verification (CHAIN_LEN=32, WORD_W=8, bench models a 32-flop chain enabled by ccff_clk_en)
REQ-031 Load words 0x01,0x80,0xFF,0x5A back-to-back -> exactly 32 contiguous ccff_clk_en cycles, done pulse once, chain image = 0x5AFF8001 (tail-end first).
REQ-032 Readback after REQ-031 -> rd_data 0x01,0x80,0xFF,0x5A in order; chain image unchanged afterwards.
REQ-033 Load with cfg_valid gap of 5 cycles after word 2 -> ccff_clk_en low for those cycles, chain image still correct.
REQ-034 Readback with rd_ready held low 10 cycles on word 1 -> rd_data stable, no shift during stall, final image intact.
REQ-035 CHAIN_LEN=13: load 0xAB,0x1F -> only 13 shifts, cfg_ready low after word 2; readback -> 0xAB,0x1F&0x1F=0x1F with bits[7:5]=0.
REQ-036 prog_reset_n low at shift 17 of a load -> all outputs 0 asynchronously; a new load then completes normally with 32 shifts.
